// File: rtl/mem_responder.sv
// Memory-side endpoint: line-refill reads as BEATS-beat bursts,
// byte-masked single-chunk writes, periodic refresh that NACKs reads.
module mem_responder #(
  parameter int ADDR_BITS      = 28,
  parameter int DATA_BITS      = 128,
  parameter int BEATS          = 4,
  parameter int DEPTH_LG       = 10,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [ADDR_BITS-1:0]   req_addr,
  input  logic                   req_rw,
  input  logic                   req_data_valid,
  output logic                   req_data_ready,
  input  logic [DATA_BITS-1:0]   req_data_bits,
  input  logic [DATA_BITS/8-1:0] req_data_mask,
  input  logic [1:0]             req_data_offset,
  output logic                   resp_val,
  output logic                   resp_nack,
  output logic [DATA_BITS-1:0]   resp_data
);

  localparam int BL = $clog2(BEATS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int RW =
    (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int NB = DATA_BITS / 8;
  localparam int LA = DEPTH_LG - BL;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    NACK,
    RD_BURST,
    WR_COMMIT
  } state_t;

  state_t                state;
  logic [DATA_BITS-1:0]  mem [2**DEPTH_LG];
  logic [RW-1:0]         ref_cnt;
  logic                  refresh_active;
  logic [LW-1:0]         wait_cnt;
  logic [BL:0]           beat;
  logic [LA-1:0]         line_addr;
  logic [DEPTH_LG-1:0]   rd_idx;
  logic [DEPTH_LG-1:0]   wr_idx;
  logic [DATA_BITS-1:0]  wr_data;
  logic [NB-1:0]         wr_mask;
  logic                  accept;
  logic                  is_wr;
  logic                  unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
    end else if (ref_cnt == RW'(REFRESH_PERIOD - 1)) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  generate
    if (REFRESH_CYCLES == 0) begin : g_no_ref
      assign refresh_active = 1'b0;
    end else begin : g_ref
      assign refresh_active = ref_cnt < RW'(REFRESH_CYCLES);
    end
  endgenerate

  assign req_rdy = (state == IDLE) & ~refresh_active;
  assign accept  = req_val & req_rdy;
  assign is_wr   = req_rw & req_data_valid;
  assign rd_idx  = {line_addr, beat[BL-1:0]};

  // Upper address bits alias; low bits are ignored for both kinds
  assign unused = ^{req_addr[ADDR_BITS-1:DEPTH_LG], req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      beat           <= '0;
      resp_val       <= 1'b0;
      resp_nack      <= 1'b0;
      resp_data      <= '0;
      req_data_ready <= 1'b0;
    end else begin
      resp_nack      <= 1'b0;
      req_data_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && is_wr) begin
            state          <= WR_COMMIT;
            req_data_ready <= 1'b1;
            wr_idx  <= {req_addr[DEPTH_LG-1:2], req_data_offset};
            wr_data <= req_data_bits;
            wr_mask <= req_data_mask;
          end else if (accept) begin
            state     <= RD_WAIT;
            wait_cnt  <= '0;
            line_addr <= req_addr[DEPTH_LG-1:BL];
          end
        end
        RD_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == LW'(LATENCY - 1)) begin
            if (refresh_active) begin
              state     <= NACK;
              resp_nack <= 1'b1;
            end else begin
              state     <= RD_BURST;
              resp_val  <= 1'b1;
              resp_data <= mem[{line_addr, BL'(0)}];
              beat      <= (BL+1)'(1);
            end
          end
        end
        NACK: state <= IDLE;
        RD_BURST: begin
          if (beat == (BL+1)'(BEATS)) begin
            state     <= IDLE;
            resp_val  <= 1'b0;
            resp_data <= '0;
          end else begin
            resp_data <= mem[rd_idx];
            beat      <= beat + 1'b1;
          end
        end
        WR_COMMIT: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == WR_COMMIT) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_mask[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder: bursts, masked
// writes, refresh NACKs, reset behaviour and address aliasing.
module tb_mem_responder;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [27:0]   req_addr;
  logic          req_rw;
  logic          req_data_valid;
  logic          req_data_ready;
  logic [127:0]  req_data_bits;
  logic [15:0]   req_data_mask;
  logic [1:0]    req_data_offset;
  logic          resp_val;
  logic          resp_nack;
  logic [127:0]  resp_data;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .req_addr        (req_addr),
    .req_rw          (req_rw),
    .req_data_valid  (req_data_valid),
    .req_data_ready  (req_data_ready),
    .req_data_bits   (req_data_bits),
    .req_data_mask   (req_data_mask),
    .req_data_offset (req_data_offset),
    .resp_val        (resp_val),
    .resp_nack       (resp_nack),
    .resp_data       (resp_data)
  );

  int total = 0;
  int bad   = 0;

  // Expected refresh counter value of the current cycle
  logic [7:0] rc;
  always @(posedge clk) rc <= reset ? 8'd0 : rc + 8'd1;

  typedef struct {
    logic              wr;
    logic [27:0]       addr;
    logic              rw;
    logic              dv;
    logic [127:0]      data;
    logic [15:0]       mask;
    logic [1:0]        off;
    logic [3:0][127:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t wv(
    input logic [27:0] a, input logic [127:0] d,
    input logic [15:0] m, input logic [1:0] o);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.rw = 1'b1; v.dv = 1'b1;
    v.data = d; v.mask = m; v.off = o; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t rv(
    input logic [27:0] a, input logic rw, input logic dv,
    input logic [127:0] e0, input logic [127:0] e1,
    input logic [127:0] e2, input logic [127:0] e3);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.rw = rw; v.dv = dv;
    v.data = '0; v.mask = '0; v.off = '0;
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_val = 1'b0; req_addr = '0; req_rw = 1'b0;
    req_data_valid = 1'b0; req_data_bits = '0;
    req_data_mask = '0; req_data_offset = '0;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (req_rdy !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL rdy_timeout got=%0b want=1", req_rdy);
    end else begin
      chk("rdy_vs_refresh", req_rdy, rc >= 8'd8);
    end
  endtask

  task automatic do_write(input vec_t v);
    wait_rdy();
    req_val = 1'b1; req_addr = v.addr; req_rw = 1'b1;
    req_data_valid = 1'b1; req_data_bits = v.data;
    req_data_mask = v.mask; req_data_offset = v.off;
    @(negedge clk);
    idle_inputs();
    chk("wr_ready_pulse", req_data_ready, 1'b1);
    chk("wr_busy_rdy", req_rdy, 1'b0);
    @(negedge clk);
    chk("wr_ready_end", req_data_ready, 1'b0);
  endtask

  task automatic do_read(input vec_t v);
    int   tries = 0;
    logic nk;
    logic [7:0] r4;
    do begin
      wait_rdy();
      r4 = rc + 8'd4;
      nk = r4 < 8'd8;
      req_val = 1'b1; req_addr = v.addr;
      req_rw = v.rw; req_data_valid = v.dv;
      @(negedge clk);
      idle_inputs();
      chk("rd_no_wr_pulse", req_data_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
        chk("rd_wait_quiet", {resp_val, resp_nack}, 2'b00);
        @(negedge clk);
      end
      if (nk) begin
        chk("rd_nack", {resp_val, resp_nack}, 2'b01);
        @(negedge clk);
        chk("rd_nack_end", {resp_val, resp_nack}, 2'b00);
      end else begin
        for (int k = 0; k < 4; k++) begin
          chk("beat_val", resp_val, 1'b1);
          chk("beat_data", resp_data, v.exp[k]);
          @(negedge clk);
        end
        chk("burst_end_val", resp_val, 1'b0);
        chk("burst_end_data", resp_data, 128'h0);
      end
      tries++;
    end while (nk && tries < 3);
  endtask

  initial begin
    logic [127:0] ones, elevens, masked;
    vec_t lineA;
    int n;
    ones    = {16{8'hFF}};
    elevens = {16{8'h11}};
    masked  = {{12{8'h11}}, {4{8'hFF}}};

    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_rdy", req_rdy, 1'b0);
    chk("rst_val", resp_val, 1'b0);
    chk("rst_nack", resp_nack, 1'b0);
    chk("rst_dready", req_data_ready, 1'b0);
    chk("rst_data", resp_data, 128'h0);

    reset = 1'b0;
    chk("post_rst_rdy", req_rdy, 1'b0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_rdy", req_rdy, 1'b0);
    end
    @(negedge clk);
    chk("post_rst_rdy_up", req_rdy, 1'b1);

    lineA = rv(28'h43, 1'b0, 1'b0, 128'hA0, 128'hA1,
               128'hA2, 128'hA3);
    tbl.push_back(wv(28'h40, 128'hA0, 16'hFFFF, 2'd0));
    tbl.push_back(wv(28'h40, 128'hA1, 16'hFFFF, 2'd1));
    tbl.push_back(wv(28'h40, 128'hA2, 16'hFFFF, 2'd2));
    tbl.push_back(wv(28'h40, 128'hA3, 16'hFFFF, 2'd3));
    tbl.push_back(lineA);
    tbl.push_back(wv(28'h10, elevens, 16'hFFFF, 2'd0));
    tbl.push_back(wv(28'h10, 128'hC1, 16'hFFFF, 2'd1));
    tbl.push_back(wv(28'h10, 128'hC2, 16'hFFFF, 2'd2));
    tbl.push_back(wv(28'h10, 128'hC3, 16'hFFFF, 2'd3));
    tbl.push_back(wv(28'h10, ones, 16'h000F, 2'd0));
    tbl.push_back(rv(28'h12, 1'b0, 1'b0, masked, 128'hC1,
                     128'hC2, 128'hC3));
    tbl.push_back(wv(28'h400, 128'hBEEF, 16'hFFFF, 2'd0));
    tbl.push_back(wv(28'h000, 128'hD1, 16'hFFFF, 2'd1));
    tbl.push_back(wv(28'h000, 128'hD2, 16'hFFFF, 2'd2));
    tbl.push_back(wv(28'h401, 128'hD3, 16'hFFFF, 2'd3));
    tbl.push_back(rv(28'h000, 1'b1, 1'b0, 128'hBEEF,
                     128'hD1, 128'hD2, 128'hD3));
    tbl.push_back(rv(28'h402, 1'b0, 1'b1, 128'hBEEF,
                     128'hD1, 128'hD2, 128'hD3));

    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i]);
      else           do_read(tbl[i]);
    end

    // Read accepted just before the refresh window opens
    n = 0;
    while (rc != 8'd254 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL nack_sync_timeout got=%0d want=254", rc);
    end
    chk("nack_rdy_pre", req_rdy, 1'b1);
    req_val = 1'b1; req_addr = 28'h40;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("nack_quiet", {resp_val, resp_nack}, 2'b00);
    @(negedge clk);
    chk("nack_pulse", {resp_val, resp_nack}, 2'b01);
    @(negedge clk);
    chk("nack_once", resp_nack, 1'b0);
    n = 0;
    while (rc < 8'd8 && n < 20) begin
      chk("nack_rdy_low", req_rdy, 1'b0);
      chk("nack_no_val", resp_val, 1'b0);
      @(negedge clk);
      n++;
    end
    chk("nack_rdy_up", req_rdy, 1'b1);
    do_read(lineA);

    // Reset after beat 1 must cut the burst short
    wait_rdy();
    req_val = 1'b1; req_addr = 28'h40;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    chk("mid_beat0", resp_data, 128'hA0);
    @(negedge clk);
    chk("mid_beat1", resp_data, 128'hA1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_val", resp_val, 1'b0);
    chk("mid_rst_data", resp_data, 128'h0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_beats", {resp_val, resp_nack}, 2'b00);
    end
    do_read(lineA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
